fir_out_capture: RTL

- Receive-side companion to the FIR8_order filter.
- Samples the filter's 10-bit output stream, applies optional decimation and buffers the kept samples in a small synchronous FIFO.
- Presents the buffered samples to a downstream reader over a valid/ready handshake.
- Flags lost samples with a sticky overflow bit.

---
 rtl/fir_out_capture.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fir_out_capture.sv
// fir_out_capture: captures the FIR8_order output stream, optionally decimates
// it, and buffers kept samples in a small first-word-fall-through FIFO read
// over a valid/ready handshake. Lost samples raise a sticky overflow flag.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   enable, data_in   filter sample strobe and 10-bit unsigned sample
//   out_valid/_ready  reader handshake; out_data is the FIFO head (0 when empty)
//   fifo_count        stored entries, 0..DEPTH
//   overflow          sticky drop flag, cleared by clear_ovf (a drop wins)
//   peak_out          largest kept sample since reset (FIR_CAP_PEAK_EN only)
//
// Optional feature macro: FIR_CAP_PEAK_EN adds the peak_out tracker.
// Latency: a sample pushed at edge N is visible on out_data after edge N.
// Backpressure: a kept sample arriving while full is dropped unless a pop
// frees a slot in the same cycle.
module fir_out_capture #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 8,
  parameter int DECIM  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  input  logic                     clear_ovf
`ifdef FIR_CAP_PEAK_EN
  ,
  output logic [DATA_W-1:0]        peak_out
`endif
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  // Keep the counter at least 1 bit wide so DECIM=1 still elaborates.
  localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECIM - 1);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic keep, full, pop, push, drop;

  always_comb begin
    keep = enable && (dcnt_q == '0);
    full = (cnt_q == FULL_CNT);
    pop  = (cnt_q != '0) && out_ready;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    push = keep && (!full || pop);
    drop = keep && !push;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    dcnt_d   = dcnt_q;
    ovf_d    = ovf_q;

    if (enable) begin
      dcnt_d = (dcnt_q == DCNT_LAST) ? '0 : dcnt_q + 1'b1;
    end
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;

    // Set-dominant: a drop in the clearing cycle keeps the flag raised.
    if (drop)           ovf_d = 1'b1;
    else if (clear_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dcnt_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dcnt_q   <= dcnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; stale entries are never visible because out_data
  // is gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= data_in;
  end

  assign out_valid  = (cnt_q != '0);
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count = cnt_q;
  assign overflow   = ovf_q;

`ifdef FIR_CAP_PEAK_EN
  logic [DATA_W-1:0] peak_q, peak_d;

  // Tracks every kept sample, including ones dropped for lack of space.
  always_comb begin
    peak_d = peak_q;
    if (keep && (data_in > peak_q)) peak_d = data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) peak_q <= '0;
    else       peak_q <= peak_d;
  end

  assign peak_out = peak_q;
`endif

endmodule
